// File: rtl/csa_final_adder_seq.sv
// Resolves a carry-save pair to binary (sum + 2*carry), CHUNK bits per cycle; latency NCHUNK cycles.
// Backpressure: in_ready only in IDLE; a finished result is held in DONE until out_ready.
module csa_final_adder_seq #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  localparam int RES_W  = WIDTH + 2;
  localparam int NCHUNK = (RES_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BASE_W = $clog2(PAD_W);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [BASE_W-1:0] CHUNK_BASE = BASE_W'(CHUNK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   a_q, a_d;
  logic [PAD_W-1:0]   b_q, b_d;
  logic [PAD_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cflop_q, cflop_d;

  logic [BASE_W-1:0]  base;
  logic [CHUNK-1:0]   a_slice;
  logic [CHUNK-1:0]   b_slice;
  logic [CHUNK:0]     slice_sum;
  logic               pad_nz;

  // Operands are zero-padded up to a whole number of chunks so the last
  // (possibly partial) slice simply sees zeros in its missing upper bits.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    idx_d     = idx_q;
    cflop_d   = cflop_q;

    base      = BASE_W'(idx_q) * CHUNK_BASE;
    a_slice   = a_q[base +: CHUNK];
    b_slice   = b_q[base +: CHUNK];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, cflop_q};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = PAD_W'({2'b00, sum_in});
          b_d     = PAD_W'({1'b0, carry_in, 1'b0});
          res_d   = '0;
          idx_d   = '0;
          cflop_d = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        res_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
        cflop_d              = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cflop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cflop_q <= cflop_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign result    = res_q[RES_W-1:0];

  // Bits above RES_W exist only as chunk padding and must never become set.
  if (PAD_W > RES_W) begin : g_pad
    assign pad_nz = |res_q[PAD_W-1:RES_W];
  end else begin : g_nopad
    assign pad_nz = 1'b0;
  end

  // RES_W covers the worst case, so the top slice can never carry out.
  a_no_top_carry : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_ADD && idx_q == LAST_IDX) |-> !slice_sum[CHUNK]);

  a_no_pad_bits : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DONE) |-> !pad_nz);

endmodule

// File: tb/tb_csa_final_adder_seq.sv
// Bench for csa_final_adder_seq: CHUNK=4, CHUNK=1 and CHUNK=12 instances against sum + 2*carry.
module tb_csa_final_adder_seq;

  logic       clk;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [9:0] sum_in    [3];
  logic [9:0] carry_in  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [11:0] result   [3];
  logic       busy      [3];

  int n_chk;
  int n_fail;
  int lat_of [3];

  typedef struct {
    logic [9:0]  s;
    logic [9:0]  c;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [8];

  csa_final_adder_seq #(.WIDTH(10), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sum_in(sum_in[0]), .carry_in(carry_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .busy(busy[0])
  );

  csa_final_adder_seq #(.WIDTH(10), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sum_in(sum_in[1]), .carry_in(carry_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .busy(busy[1])
  );

  csa_final_adder_seq #(.WIDTH(10), .CHUNK(12)) dut_c12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sum_in(sum_in[2]), .carry_in(carry_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(result[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction with out_ready held high; checks latency, value and 1-cycle pulse.
  task automatic do_op(input int d, input logic [9:0] s, input logic [9:0] c,
                       input logic [11:0] exp, input string tag);
    int n;
    @(negedge clk);
    sum_in[d]    = s;
    carry_in[d]  = c;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready[d]), 32'd1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    check({tag, " busy"}, 32'(busy[d]), 32'd1);
    n = 0;
    while (!out_valid[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat_of[d]));
    check({tag, " result"}, 32'(result[d]), 32'(exp));
    @(negedge clk);
    check({tag, " pulse_width"}, 32'(out_valid[d]), 32'd0);
  endtask

  task automatic rand_run(input int d);
    int n;
    logic [9:0]  s;
    logic [9:0]  c;
    logic [11:0] exp;
    for (int i = 0; i < 1000; i++) begin
      s   = 10'($urandom_range(0, 1023));
      c   = 10'($urandom_range(0, 1023));
      exp = 12'(s) + (12'(c) << 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sum_in[d]    = s;
      carry_in[d]  = c;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b0;
      n = 0;
      while (!in_ready[d] && n < 64) begin
        @(negedge clk);
        n++;
      end
      check("rand accept_bound", 32'(n < 64), 32'd1);
      @(negedge clk);
      in_valid[d] = 1'b0;
      sum_in[d]   = 10'($urandom_range(0, 1023));
      n = 0;
      while (!out_valid[d] && n < 64) begin
        @(negedge clk);
        n++;
      end
      check("rand latency", 32'(n), 32'(lat_of[d]));
      check("rand result", 32'(result[d]), 32'(exp));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand hold", 32'({out_valid[d], result[d]}), 32'({1'b1, exp}));
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      check("rand drop", 32'(out_valid[d]), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    n_chk  = 0;
    n_fail = 0;
    lat_of[0] = 3;
    lat_of[1] = 12;
    lat_of[2] = 1;

    vecs[0] = '{s: 10'h3FF, c: 10'h3FF, exp: 12'hBFD};
    vecs[1] = '{s: 10'h000, c: 10'h000, exp: 12'h000};
    vecs[2] = '{s: 10'h001, c: 10'h200, exp: 12'h401};
    vecs[3] = '{s: 10'h3FF, c: 10'h000, exp: 12'h3FF};
    vecs[4] = '{s: 10'h000, c: 10'h3FF, exp: 12'h7FE};
    vecs[5] = '{s: 10'h2AA, c: 10'h155, exp: 12'h554};
    vecs[6] = '{s: 10'h200, c: 10'h3FF, exp: 12'h9FE};
    vecs[7] = '{s: 10'h0F0, c: 10'h00F, exp: 12'h10E};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      sum_in[d]    = '0;
      carry_in[d]  = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      check("reset in_ready", 32'(in_ready[d]), 32'd1);
      check("reset out_valid", 32'(out_valid[d]), 32'd0);
      check("reset busy", 32'(busy[d]), 32'd0);
      check("reset result", 32'(result[d]), 32'd0);
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        do_op(d, vecs[i].s, vecs[i].c, vecs[i].exp, $sformatf("vec%0d dut%0d", i, d));
      end
    end

    // Stalled consumer: result and out_valid held, no new accept.
    @(negedge clk);
    sum_in[0] = 10'h155; carry_in[0] = 10'h0AA; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 64) begin
      check("stall in_ready_add", 32'(in_ready[0]), 32'd0);
      @(negedge clk);
      n++;
    end
    check("stall latency", 32'(n), 32'd3);
    repeat (5) begin
      check("stall out_valid", 32'(out_valid[0]), 32'd1);
      check("stall result", 32'(result[0]), 32'h2A9);
      check("stall in_ready", 32'(in_ready[0]), 32'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("stall release out_valid", 32'(out_valid[0]), 32'd0);
    check("stall release in_ready", 32'(in_ready[0]), 32'd1);

    // Reset during the second ADD cycle discards the operation.
    @(negedge clk);
    sum_in[0] = 10'h3FF; carry_in[0] = 10'h3FF; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst busy", 32'(busy[0]), 32'd0);
    check("midrst result", 32'(result[0]), 32'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0]) pulses++;
    end
    check("midrst no_pulse", 32'(pulses), 32'd0);
    do_op(0, 10'd7, 10'd3, 12'h00D, "after_rst");

    // in_valid held with changing data while busy: only the first pair is resolved.
    @(negedge clk);
    sum_in[0] = 10'h123; carry_in[0] = 10'h045; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      sum_in[0]   = 10'($urandom_range(0, 1023));
      carry_in[0] = 10'($urandom_range(0, 1023));
      n++;
    end while (!out_valid[0] && n < 64);
    in_valid[0] = 1'b0;
    check("hold_valid latency", 32'(n), 32'd4);
    check("hold_valid result", 32'(result[0]), 32'h1AD);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) pulses++;
    end
    check("hold_valid one_result", 32'(pulses), 32'd0);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
